hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core, sitting beside the main decoder in ID.
- Detects load-use and branch-operand hazards, and inserts stall cycles with a small FSM.
- Resolves beq/bne/j in ID, drives PC source select, IF/ID flush and ID/EX bubble.
- Honours a global freeze from multi-cycle memory.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- BR_ALU_STALL, 1, stall cycles when a branch source is written by the ALU op in EX (1..3).
- BR_LOAD_STALL, 2, stall cycles when a branch source is loaded by the lw in EX (1..3, must be >= BR_ALU_STALL).
- CNT_W, 2, stall counter width (must hold BR_LOAD_STALL-1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; state cleared immediately on assertion.
- mem_busy  in  1  global freeze request from instruction/data memory.
- id_valid  in  1  IF/ID holds a real instruction (0 after a flush).
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source (R-type, beq, bne, sw).
- id_branch, id_bne, id_jump  in  1  decoder outputs for the instruction in ID.
- id_cmp_equal  in  1  ID-stage register comparator result.
- ex_memread, ex_regwrite  in  1  ID/EX control bits.
- ex_rd  in  REG_ADDR_W  destination after RegDst mux in EX.
- mem_memread  in  1  EX/MEM MemRead.
- mem_rd  in  REG_ADDR_W  EX/MEM destination.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- id_bubble  out  1  zero ID/EX control bits (ID_Flush).
- if_flush  out  1  zero IF/ID on next edge.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 unused.

Behaviour:
- Match rule: match(r) = (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt)). Register 0 never causes a hazard.
- need, computed only when id_valid=1 and not id_jump:
  - branch (id_branch | id_bne) with ex_memread && match(ex_rd): need = BR_LOAD_STALL.
  - else branch with ex_regwrite && match(ex_rd): need = BR_ALU_STALL.
  - else branch with mem_memread && match(mem_rd): need = 1.
  - else non-branch with ex_memread && match(ex_rd): need = 1.
  - else need = 0.
- FSM states: RUN, HOLD. Register cnt[CNT_W-1:0].
- RUN, need=0: pc_write=1, ifid_write=1, id_bubble=0.
  - id_jump: pc_sel=10, if_flush=1.
  - id_branch & id_cmp_equal, or id_bne & !id_cmp_equal: pc_sel=01, if_flush=1.
  - otherwise: pc_sel=00, if_flush=0.
- RUN, need>0: pc_write=0, ifid_write=0, id_bubble=1, if_flush=0, pc_sel=00.
  - need=1: stay in RUN.
  - need>1: go to HOLD with cnt = need-2.
- HOLD: same stall outputs as a stall in RUN; hazards are not re-evaluated.
  - cnt=0: go to RUN.
  - cnt>0: decrement cnt.
- After a stall ends, the branch resolves in RUN on the next cycle using the then-current id_cmp_equal.
- mem_busy=1, any state: pc_write=0, ifid_write=0, id_bubble=0, if_flush=0, pc_sel=00. State and cnt are frozen. mem_busy has priority over all other conditions.
- Jump never stalls; it redirects in its first ID cycle.
- id_valid=0: need=0, no redirect, pc_write=ifid_write=1.
- Reset asserted: state=RUN, cnt=0. Outputs are forced to pc_write=0, ifid_write=0, id_bubble=1, if_flush=1, pc_sel=00 while reset is low.
- Reset asserted mid-HOLD aborts the stall; there is no carry-over after release.
- Latency: stall and redirect outputs are combinational in the same cycle as the ID inputs; FSM adds state only for multi-cycle stalls.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0].
  - perf_stall_cycles increments on every non-frozen cycle with pc_write=0 and reset high.
  - perf_redirects increments on every cycle with if_flush=1 and reset high.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg: pc_sel encodings (PCSEL_SEQ, PCSEL_BR, PCSEL_JMP), FSM state encoding, and the MIPS opcode constants already used by the decoder.
- One sub-module: hazard_detect, the purely combinational need computation. The FSM and output logic stay in hazard_flush_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_rd=2; ID add with rs=2 -> exactly 1 cycle of pc_write=0, ifid_write=0, id_bubble=1; next cycle normal.
- Load-branch: ex_memread=1, ex_rd=3; ID beq with rt=3, later id_cmp_equal=1 -> 2 stall cycles (RUN then HOLD), then pc_sel=01 and if_flush=1.
- Zero register and no-hazard branches:
  - ex_memread=1, ex_rd=0, id_rs=0 -> no stall.
  - beq with id_cmp_equal=1 -> pc_sel=01.
  - bne with id_cmp_equal=1 -> pc_sel=00, if_flush=0.
- Jump: id_jump=1 while ex_memread=1 and ex_rd matches id_rs -> no stall; pc_sel=10, if_flush=1 in the same cycle.
- Freeze: mem_busy=1 for 3 cycles during HOLD -> all enables 0, id_bubble=0, cnt held; after release, HOLD completes its remaining cycle.
- Reset: reset driven low mid-HOLD -> outputs take their reset values immediately; after release, state=RUN and cnt=0. With HAZARD_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the ID-stage hazard/flush sequencer.
package hazard_pkg;
   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_JMP = 2'b10;

   typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational stall-length computation for the instruction in ID.
module hazard_detect #(
   parameter int REG_ADDR_W    = 5,
   parameter int BR_ALU_STALL  = 1,
   parameter int BR_LOAD_STALL = 2
) (
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs,
   input  logic [REG_ADDR_W-1:0] i_id_rt,
   input  logic                  i_id_uses_rt,
   input  logic                  i_id_branch,
   input  logic                  i_id_bne,
   input  logic                  i_id_jump,
   input  logic                  i_ex_memread,
   input  logic                  i_ex_regwrite,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_mem_memread,
   input  logic [REG_ADDR_W-1:0] i_mem_rd,
   output logic [1:0]            o_need
);
   logic w_br, w_ex_hit, w_mem_hit;

   function automatic logic f_match(input logic [REG_ADDR_W-1:0] r, rs, rt, input logic uses_rt);
      return (r != '0) && (r == rs || (uses_rt && r == rt));
   endfunction

   assign w_br      = i_id_branch | i_id_bne;
   assign w_ex_hit  = f_match(i_ex_rd, i_id_rs, i_id_rt, i_id_uses_rt);
   assign w_mem_hit = f_match(i_mem_rd, i_id_rs, i_id_rt, i_id_uses_rt);

   // Non-branch ALU results are forwarded, so only a load in EX stalls them.
   assign o_need = (!i_id_valid || i_id_jump)            ? 2'd0 :
                   (w_br && i_ex_memread && w_ex_hit)    ? 2'(BR_LOAD_STALL) :
                   (w_br && i_ex_regwrite && w_ex_hit)   ? 2'(BR_ALU_STALL) :
                   (w_br && i_mem_memread && w_mem_hit)  ? 2'd1 :
                   (!w_br && i_ex_memread && w_ex_hit)   ? 2'd1 : 2'd0;
endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: ID-stage stall/flush/PC-select sequencer for the 5-stage MIPS core.
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and redirect performance counters.
module hazard_flush_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W    = 5,
   parameter int BR_ALU_STALL  = 1,
   parameter int BR_LOAD_STALL = 2,
   parameter int CNT_W         = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_busy,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  id_branch,
   input  logic                  id_bne,
   input  logic                  id_jump,
   input  logic                  id_cmp_equal,
   input  logic                  ex_memread,
   input  logic                  ex_regwrite,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_memread,
   input  logic [REG_ADDR_W-1:0] mem_rd,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_redirects,
`endif
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  id_bubble,
   output logic                  if_flush,
   output logic [1:0]            pc_sel
);
   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [1:0]       w_need;
   logic             w_taken;

   hazard_detect #(
      .REG_ADDR_W   (REG_ADDR_W),
      .BR_ALU_STALL (BR_ALU_STALL),
      .BR_LOAD_STALL(BR_LOAD_STALL)
   ) u_detect (
      .i_id_valid   (id_valid),
      .i_id_rs      (id_rs),
      .i_id_rt      (id_rt),
      .i_id_uses_rt (id_uses_rt),
      .i_id_branch  (id_branch),
      .i_id_bne     (id_bne),
      .i_id_jump    (id_jump),
      .i_ex_memread (ex_memread),
      .i_ex_regwrite(ex_regwrite),
      .i_ex_rd      (ex_rd),
      .i_mem_memread(mem_memread),
      .i_mem_rd     (mem_rd),
      .o_need       (w_need)
   );

   assign w_taken = id_valid && ((id_branch && id_cmp_equal) || (id_bne && !id_cmp_equal));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      id_bubble  = 1'b0;
      if_flush   = 1'b0;
      pc_sel     = PCSEL_SEQ;
      if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (r_state == S_HOLD) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         id_bubble  = 1'b1;
         if (r_cnt == '0) w_state_nx = S_RUN;
         else w_cnt_nx = r_cnt - 1'b1;
      end else if (w_need != 2'd0) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         id_bubble  = 1'b1;
         if (w_need > 2'd1) begin
            w_state_nx = S_HOLD;
            w_cnt_nx   = CNT_W'(w_need - 2'd2);
         end
      end else if (id_valid && id_jump) begin
         pc_sel   = PCSEL_JMP;
         if_flush = 1'b1;
      end else if (w_taken) begin
         pc_sel   = PCSEL_BR;
         if_flush = 1'b1;
      end
      // Reset overrides everything so the pipeline is held and flushed while low.
      if (!reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         id_bubble  = 1'b1;
         if_flush   = 1'b1;
         pc_sel     = PCSEL_SEQ;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cycles <= '0;
         perf_redirects    <= '0;
      end else begin
         if (!mem_busy && !pc_write) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (if_flush) perf_redirects <= perf_redirects + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: table-driven single-cycle vectors plus multi-cycle stall, freeze and reset sequences.
module tb_hazard_flush_ctrl;
   localparam logic [5:0] NORM  = 6'b110000;
   localparam logic [5:0] STALL = 6'b001000;
   localparam logic [5:0] BRT   = 6'b110101;
   localparam logic [5:0] JMPT  = 6'b110110;
   localparam logic [5:0] FRZ   = 6'b000000;
   localparam logic [5:0] RSTV  = 6'b001100;

   typedef struct {
      logic       busy, valid;
      logic [4:0] rs, rt;
      logic       urt, br, bne, jmp, eq, exm, exw;
      logic [4:0] exrd;
      logic       memm;
      logic [4:0] memrd;
      logic [5:0] exp;
      string      name;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b0;
   logic       mem_busy, id_valid, id_uses_rt, id_branch, id_bne, id_jump, id_cmp_equal;
   logic       ex_memread, ex_regwrite, mem_memread;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       pc_write, ifid_write, id_bubble, if_flush;
   logic [1:0] pc_sel;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_redirects;
`endif
   int n_chk = 0, n_fail = 0;
   vec_t tbl[16];
   vec_t v;

   hazard_flush_ctrl dut (
      .clk(clk), .reset(reset), .mem_busy(mem_busy), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
      .id_bne(id_bne), .id_jump(id_jump), .id_cmp_equal(id_cmp_equal),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
      .mem_memread(mem_memread), .mem_rd(mem_rd),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects),
`endif
      .pc_write(pc_write), .ifid_write(ifid_write), .id_bubble(id_bubble),
      .if_flush(if_flush), .pc_sel(pc_sel)
   );

   always #5 clk = ~clk;

   task automatic apply(input vec_t a);
      mem_busy = a.busy; id_valid = a.valid; id_rs = a.rs; id_rt = a.rt;
      id_uses_rt = a.urt; id_branch = a.br; id_bne = a.bne; id_jump = a.jmp;
      id_cmp_equal = a.eq; ex_memread = a.exm; ex_regwrite = a.exw; ex_rd = a.exrd;
      mem_memread = a.memm; mem_rd = a.memrd;
   endtask

   task automatic check(input string nm, input logic [5:0] e);
      logic [5:0] got;
      got = {pc_write, ifid_write, id_bubble, if_flush, pc_sel};
      n_chk++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got {pcw,ifw,bub,flush,sel}=%b expected %b", nm, got, e);
      end
   endtask

   task automatic cyc(input vec_t a);
      apply(a);
      @(negedge clk);
      check(a.name, a.exp);
      @(posedge clk);
      #1;
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic check_perf(input string nm, input logic [31:0] es, input logic [31:0] er);
      n_chk++;
      if (perf_stall_cycles !== es || perf_redirects !== er) begin
         n_fail++;
         $display("FAIL %s: got stall=%0d redir=%0d expected %0d %0d", nm, perf_stall_cycles, perf_redirects, es, er);
      end
   endtask
`endif

   initial begin
      //           busy valid rs    rt    urt br bne jmp eq exm exw exrd  memm memrd exp    name
      tbl[0]  = '{0, 1, 5'd1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, NORM,  "nop_add"};
      tbl[1]  = '{0, 1, 5'd2, 5'd9, 1, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0, STALL, "loaduse_rs"};
      tbl[2]  = '{0, 1, 5'd1, 5'd5, 1, 0, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0, STALL, "loaduse_rt"};
      tbl[3]  = '{0, 1, 5'd1, 5'd5, 0, 0, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0, NORM,  "rt_not_used"};
      tbl[4]  = '{0, 1, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0, NORM,  "zero_reg"};
      tbl[5]  = '{0, 1, 5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, BRT,   "beq_taken"};
      tbl[6]  = '{0, 1, 5'd1, 5'd2, 1, 0, 1, 0, 1, 0, 0, 5'd0, 0, 5'd0, NORM,  "bne_not_taken"};
      tbl[7]  = '{0, 1, 5'd1, 5'd2, 1, 0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, BRT,   "bne_taken"};
      tbl[8]  = '{0, 1, 5'd4, 5'd0, 0, 0, 0, 1, 0, 1, 1, 5'd4, 0, 5'd0, JMPT,  "jump_no_stall"};
      tbl[9]  = '{0, 1, 5'd6, 5'd1, 1, 1, 0, 0, 1, 0, 1, 5'd6, 0, 5'd0, STALL, "br_alu_stall"};
      tbl[10] = '{0, 1, 5'd7, 5'd1, 1, 0, 1, 0, 0, 0, 0, 5'd0, 1, 5'd7, STALL, "br_mem_load"};
      tbl[11] = '{0, 1, 5'd6, 5'd1, 1, 0, 0, 0, 0, 0, 1, 5'd6, 0, 5'd0, NORM,  "alu_fwd"};
      tbl[12] = '{0, 1, 5'd7, 5'd1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 1, 5'd7, NORM,  "mem_load_fwd"};
      tbl[13] = '{0, 0, 5'd2, 5'd2, 1, 1, 0, 0, 1, 1, 1, 5'd2, 0, 5'd0, NORM,  "invalid_id"};
      tbl[14] = '{1, 1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 1, 1, 5'd2, 0, 5'd0, FRZ,   "busy_run"};
      tbl[15] = '{0, 1, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, NORM,  "beq_not_taken"};

      apply(tbl[0]);
      #2 check("reset_outputs", RSTV);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      check_perf("perf_after_reset", 32'd0, 32'd0);
`endif
      for (int i = 0; i < 16; i++) cyc(tbl[i]);

      // lw r3 in EX, beq uses rt=3: RUN stall, HOLD stall with hazard gone, then resolve
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0, STALL, "ldbr_run_stall"};
      cyc(v);
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, STALL, "ldbr_hold_stall"};
      cyc(v);
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, BRT, "ldbr_resolve"};
      cyc(v);

      // freeze for three cycles inside HOLD, then the remaining HOLD cycle completes
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0, STALL, "frz_enter"};
      cyc(v);
      for (int i = 0; i < 3; i++) begin
         v = '{1, 1, 5'd1, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, FRZ, "frz_hold"};
         cyc(v);
      end
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, STALL, "frz_hold_resume"};
      cyc(v);
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, BRT, "frz_resolve"};
      cyc(v);

      // reset asserted mid-HOLD: immediate reset outputs, clean RUN afterwards
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 1, 1, 5'd3, 0, 5'd0, STALL, "rst_enter_hold"};
      cyc(v);
      v = '{0, 1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, NORM, "rst_after"};
      apply(v);
      reset = 1'b0;
      #1 check("rst_mid_hold", RSTV);
      @(posedge clk); #1;
      reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      check_perf("perf_after_midreset", 32'd0, 32'd0);
`endif
      cyc(v);
      v = '{0, 1, 5'd2, 5'd9, 1, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0, STALL, "loaduse_one"};
      cyc(v);
      v = '{0, 1, 5'd2, 5'd9, 1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, NORM, "loaduse_next_normal"};
      cyc(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
